correlator_cmd_tx: RTL and testbench

Host-side command transmitter for the correlator's UART configuration protocol. It takes one complete configuration request (sample time, active line, enable bits) and serialises it as the byte sequence the correlator's command receiver decodes. Each byte carries a command in the low nibble and data in the high nibble; the sequence ends with COMMIT. It sits in a controller FPGA or test harness and drives the correlator's RX pin.

---
 rtl/correlator_cmd_tx_if.sv | 31 +++
 rtl/correlator_cmd_tx.sv | 239 +++++++++++++++++++++++
 tb/tb_correlator_cmd_tx.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/correlator_cmd_tx_if.sv
// Request/status bundle between a configuration source and correlator_cmd_tx.
// The source holds the master side; the transmitter is the slave.
interface correlator_cmd_tx_if;
  logic        start;
  logic [63:0] sample_time;
  logic [63:0] active_line;
  logic        transmit_enable;
  logic        sample_clock_enable;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output sample_time,
    output active_line,
    output transmit_enable,
    output sample_clock_enable,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  sample_time,
    input  active_line,
    input  transmit_enable,
    input  sample_clock_enable,
    output busy,
    output done
  );
endinterface

// File: rtl/correlator_cmd_tx.sv
// Serialises one correlator configuration request into the nibble-command byte
// stream (8N1, LSB first) understood by the correlator's UART command receiver.
module correlator_cmd_tx #(
  parameter int CLK_FREQUENCY = 50000000,
  parameter int BAUD_RATE     = 230400,
  parameter int CLKS_PER_BIT  = CLK_FREQUENCY / BAUD_RATE,
  parameter int WORD_NIBBLES  = 16,
  parameter int GAP_BITS      = 0
) (
  input  logic               clk,
  input  logic               reset,
  correlator_cmd_tx_if.slave cmd,
  output logic               TX
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NIB_W  = $clog2(WORD_NIBBLES + 1);
  localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [NIB_W-1:0]  NIB_LAST  = NIB_W'(WORD_NIBBLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  localparam logic [3:0] CMD_RESET      = 4'h0;
  localparam logic [3:0] CMD_SET_ST     = 4'h1;
  localparam logic [3:0] CMD_SET_AL     = 4'h2;
  localparam logic [3:0] CMD_ENABLE     = 4'hC;
  localparam logic [3:0] CMD_COMMIT     = 4'hD;

  typedef enum logic [2:0] {
    P_IDLE, P_RST_ST, P_ST_NIB, P_RST_AL, P_AL_NIB, P_ENABLE, P_COMMIT
  } phase_t;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_GAP
  } ser_t;

  phase_t             phase_q, phase_d;
  ser_t               ser_q, ser_d;
  logic [NIB_W-1:0]   nib_q, nib_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic [63:0]        st_q, st_d;
  logic [63:0]        al_q, al_d;
  logic               te_q, te_d;
  logic               sce_q, sce_d;

  logic [7:0]         cur_byte;
  logic               bit_end;
  logic               byte_done;

  // Latched words shift right one nibble per nibble byte, so the byte to send
  // always takes the low nibble.
  always_comb begin
    cur_byte = 8'h00;
    unique case (phase_q)
      P_RST_ST: cur_byte = {CMD_SET_ST, CMD_RESET};
      P_ST_NIB: cur_byte = {st_q[3:0], CMD_SET_ST};
      P_RST_AL: cur_byte = {CMD_SET_AL, CMD_RESET};
      P_AL_NIB: cur_byte = {al_q[3:0], CMD_SET_AL};
      P_ENABLE: cur_byte = {2'b00, sce_q, te_q, CMD_ENABLE};
      P_COMMIT: cur_byte = {4'h0, CMD_COMMIT};
      default:  cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    phase_d   = phase_q;
    ser_d     = ser_q;
    nib_d     = nib_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    st_d      = st_q;
    al_d      = al_q;
    te_d      = te_q;
    sce_d     = sce_q;
    byte_done = 1'b0;
    bit_end   = (baud_q == BAUD_LAST);

    // Every serializer transition happens on a bit end, so wrapping here also
    // restarts the count on each state entry.
    if (ser_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end else begin
      baud_d = '0;
    end

    unique case (ser_q)
      S_IDLE: begin
        if (cmd.start && (phase_q == P_IDLE)) begin
          phase_d = P_RST_ST;
          nib_d   = '0;
          ser_d   = S_START;
          tx_d    = 1'b0;
          st_d    = cmd.sample_time;
          al_d    = cmd.active_line;
          te_d    = cmd.transmit_enable;
          sce_d   = cmd.sample_clock_enable;
        end
      end
      S_START: begin
        if (bit_end) begin
          ser_d   = S_DATA;
          bit_d   = 3'd0;
          shift_d = cur_byte;
          tx_d    = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            ser_d = S_STOP;
            tx_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b1, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (GAP_BITS > 0) begin
            ser_d = S_GAP;
            gap_d = '0;
          end else begin
            byte_done = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (gap_q == GAP_LAST) begin
            byte_done = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: ser_d = S_IDLE;
    endcase

    // Sequencer step: the next start bit begins on the same edge the previous
    // byte's last mark period ends.
    if (byte_done) begin
      ser_d = S_START;
      tx_d  = 1'b0;
      unique case (phase_q)
        P_RST_ST: begin
          phase_d = P_ST_NIB;
          nib_d   = '0;
        end
        P_ST_NIB: begin
          st_d = st_q >> 4;
          if (nib_q == NIB_LAST) begin
            phase_d = P_RST_AL;
            nib_d   = '0;
          end else begin
            nib_d = nib_q + 1'b1;
          end
        end
        P_RST_AL: begin
          phase_d = P_AL_NIB;
          nib_d   = '0;
        end
        P_AL_NIB: begin
          al_d = al_q >> 4;
          if (nib_q == NIB_LAST) begin
            phase_d = P_ENABLE;
            nib_d   = '0;
          end else begin
            nib_d = nib_q + 1'b1;
          end
        end
        P_ENABLE: begin
          phase_d = P_COMMIT;
          nib_d   = '0;
        end
        P_COMMIT: begin
          phase_d = P_IDLE;
          nib_d   = '0;
          ser_d   = S_IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
        default: begin
          phase_d = P_IDLE;
          ser_d   = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= P_IDLE;
      ser_q   <= S_IDLE;
      nib_q   <= '0;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      gap_q   <= '0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      st_q    <= 64'd0;
      al_q    <= 64'd0;
      te_q    <= 1'b0;
      sce_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ser_q   <= ser_d;
      nib_q   <= nib_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      st_q    <= st_d;
      al_q    <= al_d;
      te_q    <= te_d;
      sce_q   <= sce_d;
    end
  end

  assign TX       = tx_q;
  assign cmd.busy = (phase_q != P_IDLE);
  assign cmd.done = done_q;

endmodule

// File: tb/tb_correlator_cmd_tx.sv
// Scoreboard bench: three transmitters (default, short-word with gap, fast baud)
// decoded by UART receiver monitors that pop expected bytes and done times.
module tb_correlator_cmd_tx;

  localparam int CPB_A = 217;
  localparam int LAT_A = 36 * 10 * 217;
  localparam int CPB_B = 217;
  localparam int LAT_B = 12 * 12 * 217;
  localparam int CPB_C = 8;
  localparam int LAT_C = 36 * 10 * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic tx_a, tx_b, tx_c;

  correlator_cmd_tx_if if_a ();
  correlator_cmd_tx_if if_b ();
  correlator_cmd_tx_if if_c ();

  correlator_cmd_tx dut_a (.clk(clk), .reset(rst_a), .cmd(if_a), .TX(tx_a));
  correlator_cmd_tx #(.WORD_NIBBLES(4), .GAP_BITS(2))
    dut_b (.clk(clk), .reset(rst_b), .cmd(if_b), .TX(tx_b));
  correlator_cmd_tx #(.CLK_FREQUENCY(1843200))
    dut_c (.clk(clk), .reset(rst_c), .cmd(if_c), .TX(tx_c));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  exp_a[$], exp_b[$], exp_c[$];
  int unsigned dn_a[$], dn_b[$], dn_c[$];
  int          c_epoch = 0;

  // Receiver-side register model for dut_b
  logic [63:0] rx_st = 64'd0, rx_al = 64'd0, cm_st = 64'd0, cm_al = 64'd0;
  logic        rx_te = 1'b0, rx_sce = 1'b0, cm_te = 1'b0, cm_sce = 1'b0;
  int          rx_idx = 0, n_commit = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic tx_of(input int d);
    case (d)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  task automatic rx_byte(input int d, input int cpb, output logic [7:0] b, output logic ok);
    b = 8'h00;
    do @(negedge clk); while (tx_of(d) !== 1'b0);
    repeat (cpb / 2) @(negedge clk);
    ok = (tx_of(d) === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      b[i] = tx_of(d);
    end
    repeat (cpb) @(negedge clk);
    ok = ok && (tx_of(d) === 1'b1);
  endtask

  initial begin : mon_a
    logic [7:0] b;
    logic ok;
    int n;
    n = 0;
    forever begin
      rx_byte(0, CPB_A, b, ok);
      $display("A byte %0d: 0x%02h", n, b);
      n++;
      check("A framing", ok, 1'b1);
      if (exp_a.size() == 0) check("A extra byte", 64'(exp_a.size()), 64'd1);
      else check("A byte", b, exp_a.pop_front());
    end
  end

  initial begin : mon_b
    logic [7:0] b;
    logic ok;
    int n;
    n = 0;
    forever begin
      rx_byte(1, CPB_B, b, ok);
      $display("B byte %0d: 0x%02h", n, b);
      n++;
      check("B framing", ok, 1'b1);
      if (exp_b.size() == 0) check("B extra byte", 64'(exp_b.size()), 64'd1);
      else check("B byte", b, exp_b.pop_front());
      case (b[3:0])
        4'h0: rx_idx = 0;
        4'h1: begin rx_st[4*rx_idx +: 4] = b[7:4]; rx_idx++; end
        4'h2: begin rx_al[4*rx_idx +: 4] = b[7:4]; rx_idx++; end
        4'hC: begin rx_te = b[4]; rx_sce = b[5]; end
        4'hD: begin cm_st = rx_st; cm_al = rx_al; cm_te = rx_te; cm_sce = rx_sce; n_commit++; end
        default: ;
      endcase
    end
  end

  initial begin : mon_c
    logic [7:0] b;
    logic ok;
    int n, ep;
    n = 0;
    forever begin
      ep = c_epoch;
      rx_byte(2, CPB_C, b, ok);
      if (ep != c_epoch) begin
        $display("C byte discarded (reset mid-byte): 0x%02h", b);
      end else begin
        $display("C byte %0d: 0x%02h", n, b);
        n++;
        check("C framing", ok, 1'b1);
        if (exp_c.size() == 0) check("C extra byte", 64'(exp_c.size()), 64'd1);
        else check("C byte", b, exp_c.pop_front());
      end
    end
  end

  initial begin : mon_done
    forever begin
      @(negedge clk);
      if (if_a.done === 1'b1) begin
        $display("A done at cycle %0d", cyc);
        check("A busy at done", if_a.busy, 1'b0);
        if (dn_a.size() == 0) check("A extra done", 64'(dn_a.size()), 64'd1);
        else check("A done cycle", cyc, dn_a.pop_front());
      end
      if (if_b.done === 1'b1) begin
        $display("B done at cycle %0d", cyc);
        check("B busy at done", if_b.busy, 1'b0);
        if (dn_b.size() == 0) check("B extra done", 64'(dn_b.size()), 64'd1);
        else check("B done cycle", cyc, dn_b.pop_front());
      end
      if (if_c.done === 1'b1) begin
        $display("C done at cycle %0d", cyc);
        check("C busy at done", if_c.busy, 1'b0);
        if (dn_c.size() == 0) check("C extra done", 64'(dn_c.size()), 64'd1);
        else check("C done cycle", cyc, dn_c.pop_front());
      end
    end
  end

  task automatic flow_a();
    int unsigned acc;
    logic [9:0] frame;
    if_a.start = 1'b0; if_a.sample_time = 64'd0; if_a.active_line = 64'd0;
    if_a.transmit_enable = 1'b0; if_a.sample_clock_enable = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("A reset TX", tx_a, 1'b1);
    check("A reset busy", if_a.busy, 1'b0);
    check("A reset done", if_a.done, 1'b0);
    rst_a = 1'b0;
    repeat (2) @(posedge clk); #1;
    if_a.sample_time = 64'd100; if_a.active_line = 64'd0;
    if_a.transmit_enable = 1'b1; if_a.sample_clock_enable = 1'b1;
    if_a.start = 1'b1;
    exp_a.push_back(8'h10); exp_a.push_back(8'h41); exp_a.push_back(8'h61);
    for (int k = 0; k < 14; k++) exp_a.push_back(8'h01);
    exp_a.push_back(8'h20);
    for (int k = 0; k < 16; k++) exp_a.push_back(8'h02);
    exp_a.push_back(8'h3C); exp_a.push_back(8'h0D);
    @(posedge clk); #1;
    acc = cyc;
    if_a.start = 1'b0;
    if_a.sample_time = '1;
    if_a.active_line = '1;
    dn_a.push_back(acc + LAT_A);
    check("A busy after accept", if_a.busy, 1'b1);
    frame = {1'b1, 8'h10, 1'b0};
    for (int b = 0; b < 10; b++) begin
      check($sformatf("A bit%0d first cycle", b), tx_a, frame[b]);
      repeat (CPB_A - 1) @(posedge clk); #1;
      check($sformatf("A bit%0d last cycle", b), tx_a, frame[b]);
      @(posedge clk); #1;
    end
    repeat (5000 - 10 * CPB_A) @(posedge clk); #1;
    check("A busy at second start", if_a.busy, 1'b1);
    if_a.sample_time = 64'h1234; if_a.active_line = 64'h5555;
    if_a.transmit_enable = 1'b0; if_a.sample_clock_enable = 1'b0;
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    repeat (LAT_A - 5001 + 300) @(posedge clk); #1;
    check("A idle after sequence", if_a.busy, 1'b0);
  endtask

  task automatic flow_b();
    int unsigned acc;
    logic [7:0] vec [12];
    vec = '{8'h10, 8'hF1, 8'hE1, 8'hE1, 8'hB1, 8'h20,
            8'h32, 8'h02, 8'h02, 8'h02, 8'h2C, 8'h0D};
    if_b.start = 1'b0; if_b.sample_time = 64'd0; if_b.active_line = 64'd0;
    if_b.transmit_enable = 1'b0; if_b.sample_clock_enable = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("B reset TX", tx_b, 1'b1);
    rst_b = 1'b0;
    repeat (2) @(posedge clk); #1;
    if_b.sample_time = 64'hBEEF; if_b.active_line = 64'h0003;
    if_b.transmit_enable = 1'b0; if_b.sample_clock_enable = 1'b1;
    if_b.start = 1'b1;
    foreach (vec[i]) exp_b.push_back(vec[i]);
    @(posedge clk); #1;
    acc = cyc;
    if_b.start = 1'b0;
    dn_b.push_back(acc + LAT_B);
    repeat (LAT_B + 500) @(posedge clk); #1;
    check("B commit count", 64'(n_commit), 64'd1);
    check("B committed sample_time", cm_st, 64'hBEEF);
    check("B committed active_line", cm_al, 64'h3);
    check("B committed te", cm_te, 1'b0);
    check("B committed sce", cm_sce, 1'b1);
  endtask

  task automatic flow_c();
    logic [63:0] st_v, al_v;
    if_c.start = 1'b0; if_c.sample_time = 64'd0; if_c.active_line = 64'd0;
    if_c.transmit_enable = 1'b0; if_c.sample_clock_enable = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("C reset busy", if_c.busy, 1'b0);
    rst_c = 1'b0;
    repeat (2) @(posedge clk); #1;
    if_c.sample_time = 64'hFEDC_BA98_7654_3210; if_c.active_line = 64'd0;
    if_c.transmit_enable = 1'b1; if_c.sample_clock_enable = 1'b1;
    if_c.start = 1'b1;
    exp_c.push_back(8'h10);
    for (int k = 0; k < 9; k++) exp_c.push_back(8'(k * 16 + 1));
    @(posedge clk); #1;
    if_c.start = 1'b0;
    // Byte index 10 (0x91) is in data bit 2 (a zero) here.
    repeat (830) @(posedge clk); #1;
    check("C TX before reset", tx_c, 1'b0);
    rst_c = 1'b1;
    c_epoch++;
    #1;
    check("C TX in reset", tx_c, 1'b1);
    check("C busy in reset", if_c.busy, 1'b0);
    check("C done in reset", if_c.done, 1'b0);
    repeat (3) @(posedge clk); #1;
    rst_c = 1'b0;
    repeat (100) @(posedge clk); #1;
    check("C idle after reset", if_c.busy, 1'b0);
    st_v = 64'h0123_4567_89AB_CDEF;
    al_v = 64'h0F1E_2D3C_4B5A_6978;
    if_c.sample_time = st_v; if_c.active_line = al_v;
    if_c.transmit_enable = 1'b1; if_c.sample_clock_enable = 1'b0;
    if_c.start = 1'b1;
    exp_c.push_back(8'h10);
    for (int k = 0; k < 16; k++) exp_c.push_back({st_v[4*k +: 4], 4'h1});
    exp_c.push_back(8'h20);
    for (int k = 0; k < 16; k++) exp_c.push_back({al_v[4*k +: 4], 4'h2});
    exp_c.push_back(8'h1C); exp_c.push_back(8'h0D);
    @(posedge clk); #1;
    if_c.start = 1'b0;
    dn_c.push_back(cyc + LAT_C);
    repeat (LAT_C + 200) @(posedge clk); #1;
  endtask

  initial begin
    fork
      flow_a();
      flow_b();
      flow_c();
    join
    check("A bytes outstanding", 64'(exp_a.size()), 64'd0);
    check("B bytes outstanding", 64'(exp_b.size()), 64'd0);
    check("C bytes outstanding", 64'(exp_c.size()), 64'd0);
    check("A done outstanding", 64'(dn_a.size()), 64'd0);
    check("B done outstanding", 64'(dn_b.size()), 64'd0);
    check("C done outstanding", 64'(dn_c.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
